digit_projection: RTL and testbench

Upstream stage of the digit recognition pipeline. It runs binary projection on the monochrome pixel stream and produces the inputs the feature recognizer needs: row and column border RAMs, digit row/column counts, the frame phase counter and the projection-done flag. Frame 0 does row projection, frame 1 does column projection plus a border scan, and frame 2 is the recognition frame consumed downstream.

---
 rtl/digit_projection.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_digit_projection.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_projection.sv
// digit_projection
// Binary projection front end of the digit recognition pipeline.
//   frame 0 : row projection, records top/bottom line of each black band
//   frame 1 : column projection inside the recorded bands, then a column scan
//   frame 2 : results held steady (project_done_flag high) for the recognizer
// Optional build macro PROJ_NOISE_FILTER_EN: runs shorter than MIN_WIDTH
// pixels/lines are discarded instead of being recorded.

module digit_projection #(
    parameter int NUM_ROW   = 1,
    parameter int NUM_COL   = 4,
    parameter int H_PIXEL   = 480,
    parameter int V_PIXEL   = 272,
    parameter int MIN_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_vsync,
    input  logic        pixel_valid,
    input  logic        monoc,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic [10:0] row_border_addr,
    output logic [10:0] row_border_data,
    input  logic [10:0] col_border_addr,
    output logic [10:0] col_border_data,
    output logic [1:0]  frame_cnt,
    output logic        project_done_flag,
    output logic [3:0]  num_row,
    output logic [3:0]  num_col
);

    localparam int XW = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;

`ifdef PROJ_NOISE_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // A run of length L spans (end - start) == L - 1
    localparam logic [10:0] MIN_SPAN = 11'(MIN_WIDTH - 1);
    localparam logic [10:0] X_LAST   = 11'(H_PIXEL - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_PIXEL - 1);
    localparam logic [10:0] X_END    = 11'(H_PIXEL);

    typedef enum logic [2:0] {
        IDLE,
        ROW_PROJ,
        COL_PROJ,
        COL_SCAN,
        DONE
    } state_t;

    state_t state;

    logic vsync_d;
    logic vsync_rise;

    logic [10:0] row_ram [2*NUM_ROW];
    logic [10:0] col_ram [2*NUM_COL];

    logic [H_PIXEL-1:0] col_black;

    logic        line_black;
    logic        row_prev;
    logic [10:0] row_top;
    logic        col_prev;
    logic [10:0] col_left;
    logic [10:0] scan_x;

    logic        restart;
    logic        in_band;

    logic        row_eol;
    logic        row_cur;
    logic        row_last;
    logic        row_start;
    logic        row_end;
    logic        row_space;
    logic        row_commit;
    logic [10:0] row_run_top;
    logic [10:0] row_run_bot;

    logic        col_step;
    logic        col_cur;
    logic        col_last;
    logic        col_start;
    logic        col_end;
    logic        col_space;
    logic        col_commit;
    logic [10:0] col_run_left;
    logic [10:0] col_run_right;

    // Registered vsync edge detector; the FSM acts one cycle after the edge is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d    <= 1'b0;
            vsync_rise <= 1'b0;
        end else begin
            vsync_d    <= frame_vsync;
            vsync_rise <= frame_vsync & ~vsync_d;
        end
    end

    // A new projection cycle starts from IDLE, from an aborted scan, or after the recognition frame
    always_comb begin
        restart = vsync_rise &&
                  ((state == IDLE) || (state == COL_SCAN) ||
                   ((state == DONE) && (frame_cnt == 2'd2)));
    end

    // Line lies inside one of the bands recorded during row projection
    always_comb begin
        in_band = 1'b0;
        for (int k = 0; k < NUM_ROW; k++) begin
            if ((int'(num_row) > k) &&
                (ypos >= row_ram[2*k]) && (ypos <= row_ram[2*k+1])) begin
                in_band = 1'b1;
            end
        end
    end

    // Row run detection, evaluated at the last valid pixel of each line
    always_comb begin
        row_eol     = (state == ROW_PROJ) && !vsync_rise && pixel_valid && (xpos == X_LAST);
        row_cur     = line_black | ~monoc;
        row_last    = (ypos == Y_LAST);
        row_start   = row_cur && !row_prev;
        row_run_top = row_start ? ypos : row_top;
        row_run_bot = Y_LAST;
        row_end     = 1'b0;
        if (row_prev && !row_cur) begin
            row_end     = 1'b1;
            row_run_bot = ypos - 11'd1;
        end else if (row_cur && row_last) begin
            row_end = 1'b1;
        end
        row_space  = (int'(num_row) < NUM_ROW);
        row_commit = row_eol && row_end && row_space &&
                     (!FILTER_EN || ((row_run_bot - row_run_top) >= MIN_SPAN));
    end

    // Column run detection, one bitmap position per scan cycle
    always_comb begin
        col_step = (state == COL_SCAN) && !vsync_rise && (scan_x < X_END);
        col_cur  = 1'b0;
        if (scan_x < X_END) begin
            col_cur = col_black[scan_x[XW-1:0]];
        end
        col_last      = (scan_x == X_LAST);
        col_start     = col_cur && !col_prev;
        col_run_left  = col_start ? scan_x : col_left;
        col_run_right = X_LAST;
        col_end       = 1'b0;
        if (col_prev && !col_cur) begin
            col_end       = 1'b1;
            col_run_right = scan_x - 11'd1;
        end else if (col_cur && col_last) begin
            col_end = 1'b1;
        end
        col_space  = (int'(num_col) < NUM_COL);
        col_commit = col_step && col_end && col_space &&
                     (!FILTER_EN || ((col_run_right - col_run_left) >= MIN_SPAN));
    end

    // Phase FSM with the run trackers, counters and the done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            frame_cnt         <= 2'd0;
            project_done_flag <= 1'b0;
            num_row           <= 4'd0;
            num_col           <= 4'd0;
            line_black        <= 1'b0;
            row_prev          <= 1'b0;
            row_top           <= 11'd0;
            col_prev          <= 1'b0;
            col_left          <= 11'd0;
            scan_x            <= 11'd0;
        end else if (restart) begin
            state             <= ROW_PROJ;
            frame_cnt         <= 2'd0;
            project_done_flag <= 1'b0;
            num_row           <= 4'd0;
            num_col           <= 4'd0;
            line_black        <= 1'b0;
            row_prev          <= 1'b0;
            col_prev          <= 1'b0;
            scan_x            <= 11'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ROW_PROJ: begin
                    if (vsync_rise) begin
                        state     <= COL_PROJ;
                        frame_cnt <= 2'd1;
                    end else if (row_eol) begin
                        line_black <= 1'b0;
                        row_prev   <= row_cur && !row_last;
                        if (row_start) begin
                            row_top <= ypos;
                        end
                        if (row_commit) begin
                            num_row <= num_row + 4'd1;
                        end
                    end else if (pixel_valid && !monoc) begin
                        line_black <= 1'b1;
                    end
                end
                COL_PROJ: begin
                    if (pixel_valid && (xpos == X_LAST) && (ypos == Y_LAST)) begin
                        state    <= COL_SCAN;
                        scan_x   <= 11'd0;
                        col_prev <= 1'b0;
                    end
                end
                COL_SCAN: begin
                    if (col_step) begin
                        scan_x   <= scan_x + 11'd1;
                        col_prev <= col_cur;
                        if (col_start) begin
                            col_left <= scan_x;
                        end
                        if (col_commit) begin
                            num_col <= num_col + 4'd1;
                        end
                    end else begin
                        state             <= DONE;
                        project_done_flag <= 1'b1;
                    end
                end
                DONE: begin
                    if (vsync_rise) begin
                        frame_cnt <= 2'd2;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Column bitmap: black pixels inside a recorded band mark their column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_black <= '0;
        end else if (restart) begin
            col_black <= '0;
        end else if ((state == COL_PROJ) && pixel_valid && !monoc &&
                     (xpos < X_END) && in_band) begin
            col_black[xpos[XW-1:0]] <= 1'b1;
        end
    end

    // Border RAMs, written on the edge that closes an accepted run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2*NUM_ROW; i++) begin
                row_ram[i] <= 11'd0;
            end
            for (int i = 0; i < 2*NUM_COL; i++) begin
                col_ram[i] <= 11'd0;
            end
        end else begin
            if (row_commit) begin
                for (int k = 0; k < NUM_ROW; k++) begin
                    if (num_row == 4'(k)) begin
                        row_ram[2*k]   <= row_run_top;
                        row_ram[2*k+1] <= row_run_bot;
                    end
                end
            end
            if (col_commit) begin
                for (int k = 0; k < NUM_COL; k++) begin
                    if (num_col == 4'(k)) begin
                        col_ram[2*k]   <= col_run_left;
                        col_ram[2*k+1] <= col_run_right;
                    end
                end
            end
        end
    end

    // Combinational RAM reads; addresses past the table read 0
    always_comb begin
        row_border_data = 11'd0;
        for (int i = 0; i < 2*NUM_ROW; i++) begin
            if (row_border_addr == 11'(i)) begin
                row_border_data = row_ram[i];
            end
        end
        col_border_data = 11'd0;
        for (int i = 0; i < 2*NUM_COL; i++) begin
            if (col_border_addr == 11'(i)) begin
                col_border_data = col_ram[i];
            end
        end
    end

endmodule

// File: tb/tb_digit_projection.sv
// tb_digit_projection
// Drives small frames into digit_projection and compares borders, counts and
// phase against a reference built from the image with plain loops.

module tb_digit_projection;

    localparam int TB_H    = 48;
    localparam int TB_V    = 20;
    localparam int TB_NROW = 2;
    localparam int TB_NCOL = 4;
    localparam int TB_MIN  = 3;

`ifdef PROJ_NOISE_FILTER_EN
    localparam bit TB_FILTER = 1'b1;
`else
    localparam bit TB_FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_vsync = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        monoc = 1'b1;
    logic [10:0] xpos = 11'd0;
    logic [10:0] ypos = 11'd0;
    logic [10:0] row_border_addr = 11'd0;
    logic [10:0] row_border_data;
    logic [10:0] col_border_addr = 11'd0;
    logic [10:0] col_border_data;
    logic [1:0]  frame_cnt;
    logic        project_done_flag;
    logic [3:0]  num_row;
    logic [3:0]  num_col;

    always #5 clk = ~clk;

    digit_projection #(
        .NUM_ROW  (TB_NROW),
        .NUM_COL  (TB_NCOL),
        .H_PIXEL  (TB_H),
        .V_PIXEL  (TB_V),
        .MIN_WIDTH(TB_MIN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_vsync      (frame_vsync),
        .pixel_valid      (pixel_valid),
        .monoc            (monoc),
        .xpos             (xpos),
        .ypos             (ypos),
        .row_border_addr  (row_border_addr),
        .row_border_data  (row_border_data),
        .col_border_addr  (col_border_addr),
        .col_border_data  (col_border_data),
        .frame_cnt        (frame_cnt),
        .project_done_flag(project_done_flag),
        .num_row          (num_row),
        .num_col          (num_col)
    );

    // 1 = black (digit) pixel
    bit img [TB_V][TB_H];
    int exp_rows[$];
    int exp_cols[$];
    int checks = 0;
    int errors = 0;

    function automatic bit keep_run(input int s, input int e, input int held, input int limit);
        return (held < limit) && (!TB_FILTER || (e - s + 1 >= TB_MIN));
    endfunction

    // Reference: black lines form bands, bands select which pixels mark columns
    function automatic void compute_expected();
        bit lb [TB_V];
        bit cb [TB_H];
        bit cur;
        bit open;
        bit inb;
        int s;
        exp_rows.delete();
        exp_cols.delete();
        for (int y = 0; y < TB_V; y++) begin
            lb[y] = 1'b0;
            for (int x = 0; x < TB_H; x++) if (img[y][x]) lb[y] = 1'b1;
        end
        open = 1'b0;
        s = 0;
        for (int y = 0; y <= TB_V; y++) begin
            cur = 1'b0;
            if (y < TB_V) cur = lb[y];
            if (cur && !open) begin
                open = 1'b1;
                s = y;
            end else if (!cur && open) begin
                open = 1'b0;
                if (keep_run(s, y - 1, exp_rows.size() / 2, TB_NROW)) begin
                    exp_rows.push_back(s);
                    exp_rows.push_back(y - 1);
                end
            end
        end
        for (int x = 0; x < TB_H; x++) begin
            cb[x] = 1'b0;
            for (int y = 0; y < TB_V; y++) begin
                inb = 1'b0;
                for (int k = 0; k < exp_rows.size() / 2; k++)
                    if (y >= exp_rows[2*k] && y <= exp_rows[2*k+1]) inb = 1'b1;
                if (inb && img[y][x]) cb[x] = 1'b1;
            end
        end
        open = 1'b0;
        for (int x = 0; x <= TB_H; x++) begin
            cur = 1'b0;
            if (x < TB_H) cur = cb[x];
            if (cur && !open) begin
                open = 1'b1;
                s = x;
            end else if (!cur && open) begin
                open = 1'b0;
                if (keep_run(s, x - 1, exp_cols.size() / 2, TB_NCOL)) begin
                    exp_cols.push_back(s);
                    exp_cols.push_back(x - 1);
                end
            end
        end
    endfunction

    task automatic fill_rect(input int y0, input int y1, input int x0, input int x1);
        for (int y = y0; y <= y1 && y < TB_V; y++)
            for (int x = x0; x <= x1 && x < TB_H; x++)
                img[y][x] = 1'b1;
    endtask

    task automatic build_image(input int sc);
        int nrect;
        int y0;
        int x0;
        for (int y = 0; y < TB_V; y++)
            for (int x = 0; x < TB_H; x++)
                img[y][x] = 1'b0;
        case (sc)
            0: begin
                fill_rect(5, 12, 4, 8);
                fill_rect(5, 12, 12, 16);
                fill_rect(5, 12, 22, 26);
                fill_rect(5, 12, 32, 36);
            end
            1: fill_rect(14, 19, 10, 20);
            2: for (int i = 0; i < 6; i++) fill_rect(3, 8, 2 + 7*i, 4 + 7*i);
            3: begin
                fill_rect(1, 3, 5, 9);
                fill_rect(7, 9, 20, 24);
                fill_rect(13, 15, 35, 40);
            end
            4: begin
                fill_rect(4, 10, 10, 11);
                fill_rect(4, 10, 25, 30);
            end
            5: begin
            end
            default: begin
                nrect = int'($urandom_range(1, 5));
                for (int i = 0; i < nrect; i++) begin
                    y0 = int'($urandom_range(0, TB_V - 1));
                    x0 = int'($urandom_range(0, TB_H - 1));
                    fill_rect(y0, y0 + int'($urandom_range(0, 5)), x0, x0 + int'($urandom_range(0, 7)));
                end
                for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                    img[$urandom_range(0, TB_V - 1)][$urandom_range(0, TB_H - 1)] = 1'b1;
            end
        endcase
    endtask

    task automatic blank(input int n);
        pixel_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_vsync();
        frame_vsync = 1'b1;
        blank(3);
        frame_vsync = 1'b0;
        blank(4);
    endtask

    // Streams lines 0..last_line with occasional invalid cycles carrying junk
    task automatic send_frame(input int last_line);
        for (int y = 0; y < TB_V && y <= last_line; y++) begin
            for (int x = 0; x < TB_H; x++) begin
                if ($urandom_range(0, 7) == 0) begin
                    pixel_valid = 1'b0;
                    monoc = 1'($urandom_range(0, 1));
                    xpos = 11'(TB_H - 1);
                    ypos = 11'(TB_V - 1);
                    @(posedge clk);
                    #1;
                end
                pixel_valid = 1'b1;
                monoc = ~img[y][x];
                xpos = 11'(x);
                ypos = 11'(y);
                @(posedge clk);
                #1;
            end
        end
        pixel_valid = 1'b0;
        monoc = 1'b1;
        xpos = 11'd0;
        ypos = 11'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frame_cnt !== 2'd0 || project_done_flag !== 1'b0 || num_row !== 4'd0 || num_col !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got frame_cnt=%0d done=%0d num_row=%0d num_col=%0d, expected 0 0 0 0",
                     frame_cnt, project_done_flag, num_row, num_col);
        end
        rst = 1'b0;
        blank(2);
        for (int a = 0; a <= 2*TB_NCOL; a++) begin
            row_border_addr = 11'(a);
            col_border_addr = 11'(a);
            @(negedge clk);
            checks++;
            if (row_border_data !== 11'd0) begin
                errors++;
                $display("[TB] FAIL reset_row_ram[%0d]: got %0d, expected 0", a, row_border_data);
            end
            checks++;
            if (col_border_data !== 11'd0) begin
                errors++;
                $display("[TB] FAIL reset_col_ram[%0d]: got %0d, expected 0", a, col_border_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_projection();
        for (int sc = 0; sc < 12; sc++) begin
            build_image(sc);
            compute_expected();
            pulse_vsync();
            checks++;
            if (frame_cnt !== 2'd0 || num_row !== 4'd0 || num_col !== 4'd0 || project_done_flag !== 1'b0) begin
                errors++;
                $display("[TB] FAIL scene%0d start: got frame_cnt=%0d num_row=%0d num_col=%0d done=%0d, expected 0 0 0 0",
                         sc, frame_cnt, num_row, num_col, project_done_flag);
            end
            send_frame(TB_V - 1);
            pulse_vsync();
            checks++;
            if (frame_cnt !== 2'd1 || num_row !== 4'(exp_rows.size() / 2)) begin
                errors++;
                $display("[TB] FAIL scene%0d row_phase: got frame_cnt=%0d num_row=%0d, expected 1 %0d",
                         sc, frame_cnt, num_row, exp_rows.size() / 2);
            end
            send_frame(TB_V - 1);
            blank(TB_H + 10);
            checks++;
            if (project_done_flag !== 1'b1 || frame_cnt !== 2'd1) begin
                errors++;
                $display("[TB] FAIL scene%0d scan_done: got done=%0d frame_cnt=%0d, expected 1 1",
                         sc, project_done_flag, frame_cnt);
            end
            pulse_vsync();
            checks++;
            if (frame_cnt !== 2'd2 || project_done_flag !== 1'b1) begin
                errors++;
                $display("[TB] FAIL scene%0d frame2: got frame_cnt=%0d done=%0d, expected 2 1",
                         sc, frame_cnt, project_done_flag);
            end
            // An all-black recognition frame must not disturb the results
            for (int y = 0; y < TB_V; y++)
                for (int x = 0; x < TB_H; x++)
                    img[y][x] = 1'b1;
            send_frame(TB_V - 1);
            checks++;
            if (num_row !== 4'(exp_rows.size() / 2) || project_done_flag !== 1'b1 || frame_cnt !== 2'd2) begin
                errors++;
                $display("[TB] FAIL scene%0d num_row: got %0d (done=%0d fc=%0d), expected %0d (done=1 fc=2)",
                         sc, num_row, project_done_flag, frame_cnt, exp_rows.size() / 2);
            end
            checks++;
            if (num_col !== 4'(exp_cols.size() / 2)) begin
                errors++;
                $display("[TB] FAIL scene%0d num_col: got %0d, expected %0d", sc, num_col, exp_cols.size() / 2);
            end
            for (int a = 0; a <= 2*TB_NROW; a++) begin
                row_border_addr = 11'(a);
                @(negedge clk);
                checks++;
                if (a < exp_rows.size()) begin
                    if (row_border_data !== 11'(exp_rows[a])) begin
                        errors++;
                        $display("[TB] FAIL scene%0d row_ram[%0d]: got %0d, expected %0d", sc, a, row_border_data, exp_rows[a]);
                    end
                end else if (a == 2*TB_NROW && row_border_data !== 11'd0) begin
                    errors++;
                    $display("[TB] FAIL scene%0d row_ram[%0d]: got %0d, expected 0", sc, a, row_border_data);
                end
            end
            for (int a = 0; a <= 2*TB_NCOL + 1; a++) begin
                col_border_addr = (a == 2*TB_NCOL + 1) ? 11'h7FF : 11'(a);
                @(negedge clk);
                checks++;
                if (a < exp_cols.size()) begin
                    if (col_border_data !== 11'(exp_cols[a])) begin
                        errors++;
                        $display("[TB] FAIL scene%0d col_ram[%0d]: got %0d, expected %0d", sc, a, col_border_data, exp_cols[a]);
                    end
                end else if (a >= 2*TB_NCOL && col_border_data !== 11'd0) begin
                    errors++;
                    $display("[TB] FAIL scene%0d col_ram_oob[%0d]: got %0d, expected 0", sc, a, col_border_data);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_frame();
        build_image(0);
        compute_expected();
        pulse_vsync();
        send_frame(TB_V - 1);
        pulse_vsync();
        checks++;
        if (frame_cnt !== 2'd1 || num_row !== 4'(exp_rows.size() / 2)) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got frame_cnt=%0d num_row=%0d, expected 1 %0d",
                     frame_cnt, num_row, exp_rows.size() / 2);
        end
        send_frame(TB_V / 2);
        row_border_addr = 11'd0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (frame_cnt !== 2'd0 || project_done_flag !== 1'b0 || num_row !== 4'd0 ||
            num_col !== 4'd0 || row_border_data !== 11'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got fc=%0d done=%0d nr=%0d nc=%0d ram0=%0d, expected all 0",
                     frame_cnt, project_done_flag, num_row, num_col, row_border_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        blank(3);
        pulse_vsync();
        checks++;
        if (frame_cnt !== 2'd0 || num_row !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midrst_restart: got frame_cnt=%0d num_row=%0d, expected 0 0", frame_cnt, num_row);
        end
        send_frame(TB_V - 1);
        pulse_vsync();
        checks++;
        if (frame_cnt !== 2'd1 || num_row !== 4'(exp_rows.size() / 2)) begin
            errors++;
            $display("[TB] FAIL midrst_rerun: got frame_cnt=%0d num_row=%0d, expected 1 %0d",
                     frame_cnt, num_row, exp_rows.size() / 2);
        end
    endtask

    task automatic test_scan_abort();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        blank(2);
        build_image(0);
        pulse_vsync();
        send_frame(TB_V - 1);
        pulse_vsync();
        send_frame(TB_V - 1);
        blank(20);
        pulse_vsync();
        checks++;
        if (frame_cnt !== 2'd0 || project_done_flag !== 1'b0 || num_row !== 4'd0 || num_col !== 4'd0) begin
            errors++;
            $display("[TB] FAIL abort: got fc=%0d done=%0d nr=%0d nc=%0d, expected 0 0 0 0",
                     frame_cnt, project_done_flag, num_row, num_col);
        end
        blank(TB_H + 10);
        checks++;
        if (project_done_flag !== 1'b0 || frame_cnt !== 2'd0) begin
            errors++;
            $display("[TB] FAIL abort_hold: got done=%0d fc=%0d, expected 0 0", project_done_flag, frame_cnt);
        end
        pulse_vsync();
        checks++;
        if (frame_cnt !== 2'd1) begin
            errors++;
            $display("[TB] FAIL abort_next: got frame_cnt=%0d, expected 1", frame_cnt);
        end
    endtask

    initial begin
        $display("[TB] digit_projection bench, filter=%0d", TB_FILTER);
        #1;
        test_reset();
        test_projection();
        test_reset_mid_frame();
        test_scan_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
